// File: rtl/bp_cce_uc_io_fsm_pkg.sv
// bp_cce_uc_io_fsm_pkg: config, BedRock message formats and tracker entry for the uncached I/O CCE path
package bp_cce_uc_io_fsm_pkg;

  typedef enum logic {e_bp_default_cfg} bp_params_e;

  typedef struct packed {
    int unsigned paddr_width;
    int unsigned lce_id_width;
    int unsigned cce_id_width;
    int unsigned data_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_default_cfg_gp = '{paddr_width: 40, lce_id_width: 4, cce_id_width: 4, data_width: 64};

  function automatic bp_proc_param_s bp_cfg(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? bp_default_cfg_gp : '0;
  endfunction

  localparam int paddr_width_gp  = bp_default_cfg_gp.paddr_width;
  localparam int lce_id_width_gp = bp_default_cfg_gp.lce_id_width;
  localparam int cce_id_width_gp = bp_default_cfg_gp.cce_id_width;
  localparam int data_width_gp   = bp_default_cfg_gp.data_width;

  typedef enum logic [1:0] {
    e_bedrock_req_rd, e_bedrock_req_wr, e_bedrock_req_uc_rd, e_bedrock_req_uc_wr
  } bp_bedrock_req_type_e;

  typedef enum logic [2:0] {
    e_bedrock_cmd_sync, e_bedrock_cmd_set_clear, e_bedrock_cmd_transfer, e_bedrock_cmd_inv,
    e_bedrock_cmd_data, e_bedrock_cmd_uc_data, e_bedrock_cmd_uc_req_done
  } bp_bedrock_cmd_type_e;

  typedef enum logic [2:0] {
    e_bedrock_mem_rd, e_bedrock_mem_wr, e_bedrock_mem_uc_rd, e_bedrock_mem_uc_wr, e_bedrock_mem_pre
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1, e_bedrock_msg_size_2, e_bedrock_msg_size_4, e_bedrock_msg_size_8,
    e_bedrock_msg_size_16, e_bedrock_msg_size_32, e_bedrock_msg_size_64, e_bedrock_msg_size_128
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [data_width_gp-1:0]   data;
    logic [paddr_width_gp-1:0]  addr;
    bp_bedrock_msg_size_e       size;
    logic [lce_id_width_gp-1:0] src_id;
    bp_bedrock_req_type_e       msg_type;
  } bp_bedrock_lce_req_msg_s;

  typedef struct packed {
    logic [data_width_gp-1:0]   data;
    logic [paddr_width_gp-1:0]  addr;
    bp_bedrock_msg_size_e       size;
    logic [cce_id_width_gp-1:0] src_id;
    logic [lce_id_width_gp-1:0] dst_id;
    bp_bedrock_cmd_type_e       msg_type;
  } bp_bedrock_lce_cmd_msg_s;

  typedef struct packed {
    logic [data_width_gp-1:0]   data;
    logic [paddr_width_gp-1:0]  addr;
    bp_bedrock_msg_size_e       size;
    logic [lce_id_width_gp-1:0] lce_id;
    bp_bedrock_mem_type_e       msg_type;
  } bp_bedrock_mem_msg_s;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
    logic                       wr_not_rd;
  } bp_cce_uc_track_s;

  localparam int lce_req_msg_width_gp = $bits(bp_bedrock_lce_req_msg_s);
  localparam int lce_cmd_msg_width_gp = $bits(bp_bedrock_lce_cmd_msg_s);
  localparam int cce_mem_msg_width_gp = $bits(bp_bedrock_mem_msg_s);

endpackage

// File: rtl/bp_cce_uc_io_fsm_tracker.sv
// bp_cce_uc_tracker: in-order FIFO of outstanding uncached requests, popped as mem responses return
module bp_cce_uc_tracker
  import bp_cce_uc_io_fsm_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  bp_cce_uc_track_s data_i,
  input  logic             v_i,
  output bp_cce_uc_track_s data_o,
  input  logic             yumi_i,
  output logic             full_o,
  output logic             empty_o
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  bp_cce_uc_track_s mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    wptr_d = v_i ? ((wptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wptr_q + ptr_w_lp'(1)) : wptr_q;
    rptr_d = yumi_i ? ((rptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rptr_q + ptr_w_lp'(1)) : rptr_q;
    cnt_d = cnt_q + cnt_w_lp'(v_i) - cnt_w_lp'(yumi_i);
    full_o = cnt_q == cnt_w_lp'(els_p);
    empty_o = cnt_q == '0;
    data_o = mem_q[rptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/bp_cce_uc_io_fsm.sv
// bp_cce_uc_io_fsm: forwards uncached I/O LCE requests to memory and turns in-order mem responses into LCE commands
module bp_cce_uc_io_fsm
  import bp_cce_uc_io_fsm_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int max_outstanding_p = 4,
  localparam bp_proc_param_s cfg_lp = bp_cfg(bp_params_p),
  localparam int cce_id_width_lp = cfg_lp.cce_id_width
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_id_width_lp-1:0]      cce_id_i,
  input  logic [lce_req_msg_width_gp-1:0] lce_req_i,
  input  logic                            lce_req_v_i,
  output logic                            lce_req_yumi_o,
  output logic [cce_mem_msg_width_gp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_gp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,
  output logic [lce_cmd_msg_width_gp-1:0] lce_cmd_o,
  output logic                            lce_cmd_v_o,
  input  logic                            lce_cmd_ready_i,
  output logic                            error_o
);
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

  bp_bedrock_lce_req_msg_s req;
  bp_bedrock_mem_msg_s     resp, mem_cmd_q, mem_cmd_d;
  bp_bedrock_lce_cmd_msg_s lce_cmd_q, lce_cmd_d;
  bp_cce_uc_track_s        trk_push, trk_head;
  logic mem_cmd_v_q, mem_cmd_v_d, lce_cmd_v_q, lce_cmd_v_d, error_q, error_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic trk_full, trk_empty, req_wr, req_uc, fwd, resp_wr, cmd_free, lce_free, lce_hs;
  logic unused_resp_lce_id;

  assign req = lce_req_i;
  assign resp = mem_resp_i;
  assign unused_resp_lce_id = ^resp.lce_id;

  always_comb begin
    req_wr = req.msg_type == e_bedrock_req_uc_wr;
    req_uc = req_wr | (req.msg_type == e_bedrock_req_uc_rd);
    resp_wr = resp.msg_type == e_bedrock_mem_uc_wr;
    cmd_free = ~mem_cmd_v_q | mem_cmd_ready_i;
    lce_free = ~lce_cmd_v_q | lce_cmd_ready_i;
    lce_hs = lce_cmd_v_q & lce_cmd_ready_i;
    // yumis are gated by reset so nothing is consumed while the state is being cleared
    lce_req_yumi_o = reset_i & lce_req_v_i & cmd_free & (cnt_q < cnt_w_lp'(max_outstanding_p)) & ~trk_full;
    mem_resp_yumi_o = reset_i & mem_resp_v_i & ~trk_empty & lce_free;
    fwd = lce_req_yumi_o & req_uc;
    trk_push = '{lce_id: req.src_id, wr_not_rd: req_wr};
    mem_cmd_v_d = fwd | (mem_cmd_v_q & ~mem_cmd_ready_i);
    mem_cmd_d = mem_cmd_q;
    if (fwd) begin
      mem_cmd_d = '0;
      mem_cmd_d.msg_type = req_wr ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
      mem_cmd_d.addr = req.addr;
      mem_cmd_d.size = req.size;
      mem_cmd_d.data = req.data;
    end
    lce_cmd_v_d = mem_resp_yumi_o | (lce_cmd_v_q & ~lce_cmd_ready_i);
    lce_cmd_d = lce_cmd_q;
    if (mem_resp_yumi_o) begin
      lce_cmd_d = '0;
      lce_cmd_d.msg_type = trk_head.wr_not_rd ? e_bedrock_cmd_uc_req_done : e_bedrock_cmd_uc_data;
      lce_cmd_d.dst_id = trk_head.lce_id;
      lce_cmd_d.src_id = cce_id_i;
      lce_cmd_d.addr = resp.addr;
      lce_cmd_d.size = resp.size;
      lce_cmd_d.data = trk_head.wr_not_rd ? '0 : resp.data;
    end
    // dropped requests never produce an lce_cmd, so only forwarded ones are counted
    cnt_d = cnt_q + cnt_w_lp'(fwd) - cnt_w_lp'(lce_hs);
    error_d = error_q | (lce_req_yumi_o & ~req_uc) | (mem_resp_yumi_o & (resp_wr != trk_head.wr_not_rd))
            | (mem_resp_v_i & trk_empty);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      mem_cmd_v_q <= 1'b0;
      lce_cmd_v_q <= 1'b0;
      error_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_cmd_v_q <= mem_cmd_v_d;
      lce_cmd_v_q <= lce_cmd_v_d;
      error_q <= error_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_cmd_q <= mem_cmd_d;
    lce_cmd_q <= lce_cmd_d;
  end

  bp_cce_uc_tracker #(.els_p(max_outstanding_p)) u_tracker (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .data_i(trk_push),
    .v_i(fwd),
    .data_o(trk_head),
    .yumi_i(mem_resp_yumi_o),
    .full_o(trk_full),
    .empty_o(trk_empty)
  );

  assign mem_cmd_o = mem_cmd_q;
  assign mem_cmd_v_o = mem_cmd_v_q;
  assign lce_cmd_o = lce_cmd_q;
  assign lce_cmd_v_o = lce_cmd_v_q;
  assign error_o = error_q;
endmodule

// File: doc/bp_cce_uc_io_fsm.md
Name: bp_cce_uc_io_fsm

Overview:
- CCE-side consumer of the uncached LCE requests produced by the I/O-to-LCE link adapter (uc_rd/uc_wr from an I/O LCE).
- Forwards each request to memory/IO as a BedRock mem command, tracks it, and converts the in-order mem response into the LCE command the adapter expects:
  - e_bedrock_cmd_uc_data for reads.
  - e_bedrock_cmd_uc_req_done for writes.
- Registered in both directions; supports up to max_outstanding_p requests in flight.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr/block/lce_id/cce_id widths and LCE/mem message widths.
- max_outstanding_p, 4, maximum requests accepted but not yet answered on lce_cmd; must be at least 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset.
- cce_id_i  in  cce_id_width_p  this CCE's id; used as lce_cmd src_id.
- lce_req_i  in  lce_req_msg_width_lp  uncached LCE request.
- lce_req_v_i  in  1  request valid.
- lce_req_yumi_o  out  1  request consumed this cycle.
- mem_cmd_o  out  cce_mem_msg_width_lp  mem command.
- mem_cmd_v_o  out  1  command valid.
- mem_cmd_ready_i  in  1  downstream ready.
- mem_resp_i  in  cce_mem_msg_width_lp  mem response, returned in command order.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed.
- lce_cmd_o  out  lce_cmd_msg_width_lp  LCE command to requester.
- lce_cmd_v_o  out  1  command valid.
- lce_cmd_ready_i  in  1  downstream ready.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset (reset_i==0 at posedge): mem_cmd_v_o=0, lce_cmd_v_o=0, error_o=0, outstanding count=0, tracker empty. Yumis are combinational and therefore 0 while in reset.
- Request path:
  - Accept condition: lce_req_yumi_o = lce_req_v_i & (cmd reg empty | (mem_cmd_v_o & mem_cmd_ready_i)) & (count < max_outstanding_p) & tracker not full.
  - On accept, the cmd reg loads next cycle with:
    - msg_type = e_bedrock_mem_uc_wr if req is uc_wr, else e_bedrock_mem_uc_rd.
    - addr, size and data copied from the request.
    - Other fields zero.
  - On accept, {src_id, wr_not_rd} is pushed into the tracker.
  - Latency is 1 cycle from accept to mem_cmd_v_o.
  - The cmd reg is held stable until handshake.
  - Non-uc request types are accepted, dropped (no cmd, no push), and set error_o.
- Response path:
  - Accept condition: mem_resp_yumi_o = mem_resp_v_i & tracker not empty & (lce_cmd reg empty | (lce_cmd_v_o & lce_cmd_ready_i)).
  - On accept, the tracker pops and the lce_cmd reg loads next cycle with:
    - dst_id = tracked src_id; src_id = cce_id_i.
    - msg_type = uc_req_done if the tracked wr flag is set, else uc_data.
    - addr and size copied from the response.
    - data copied for reads; zero for writes.
  - If the response msg_type disagrees with the tracked wr flag, set error_o; the lce_cmd is still generated from the tracked flag.
  - A response valid while the tracker is empty is not consumed and sets error_o.
- Outstanding count:
  - +1 on lce_req accept; -1 on lce_cmd_v_o & lce_cmd_ready_i.
  - Both in the same cycle leaves the count unchanged.
  - Never exceeds max_outstanding_p, never goes below 0.
- Full throughput:
  - With ready held high, one request per cycle is accepted while count < max.
  - Registers drain and refill in the same cycle.
- Reset mid-operation discards all in-flight state; no partial outputs after reset.
- error_o clears only on reset.

Decomposition:
- Tracker entry typedef bp_cce_uc_track_s {lce_id, wr_not_rd} goes in bp_me_pkg; message enums are reused from bp_common_pkg.
- One sub-module, bp_cce_uc_tracker: a max_outstanding_p-deep 1r1w FIFO with full/empty outputs, wrapping bsg_fifo_1r1w_small.

Test Plan:
- uc_rd addr 0x8000_0040, size 8B, src 1, all readies high:
  - mem_cmd uc_rd 0x8000_0040 one cycle after yumi.
  - Response data 0xDEAD_BEEF gives lce_cmd uc_data, dst 1, src cce_id_i, data 0xDEAD_BEEF, one cycle after mem_resp_yumi_o.
- uc_wr data 0x55 to 0x8000_0000 from src 2: mem_cmd uc_wr data 0x55; the response yields uc_req_done to dst 2 with data 0.
- Six back-to-back requests, max_outstanding_p=4, no responses:
  - Exactly 4 yumis, then lce_req_yumi_o stays 0.
  - After one lce_cmd handshake, exactly one more request is accepted.
- mem_cmd_ready_i low for 5 cycles: mem_cmd_o stable, no further yumi once the cmd reg is full; resumes one per cycle when ready rises.
- mem_resp_v_i with no request outstanding → no yumi, error_o=1 and stays 1 until reset.
- Reset (reset_i=0) asserted with 3 requests outstanding:
  - Next cycle, all valids are 0 and count is 0.
  - A fresh request then completes normally.
